// File: rtl/op_dispatch_queue.sv
// FIFO-buffered op dispatcher. Each op goes to one of NUM_CH handlers, runs the
// trigger/rdy/done handshake with it, and is guarded by a clk_en-paced watchdog.
`timescale 1ns/1ps
module op_dispatch_queue #(
  parameter int OP_BITS        = 64,
  parameter int NUM_CH         = 4,
  parameter int CH_IDX_LSB     = 0,
  parameter int CH_IDX_BITS    = 4,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic [OP_BITS-1:0]        op_in,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic                      flush,
  output logic [OP_BITS-1:0]        ch_op,
  output logic [NUM_CH-1:0]         ch_trigger,
  input  logic [NUM_CH-1:0]         ch_rdy,
  input  logic [NUM_CH-1:0]         ch_done,
  output logic                      op_done,
  output logic                      err_bad_ch,
  output logic                      err_timeout,
  output logic                      idle,
  output logic [$clog2(DEPTH):0]    level,
  output logic [CNT_BITS-1:0]       ops_completed
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam int WD_BITS  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_RDY, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [OP_BITS-1:0]   mem [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [LVL_BITS-1:0]  level_q;
  logic [WD_BITS-1:0]   wd_q, wd_d;
  logic [NUM_CH-1:0]    mask_q, head_mask, trig_d;
  logic [OP_BITS-1:0]   head_op;
  logic [CH_IDX_BITS-1:0] head_idx;
  logic                 head_bad;
  logic                 push, pop;
  logic                 done_d, bad_d, to_d, cnt_inc;

  assign op_ready  = (level_q != LVL_BITS'(DEPTH));
  assign level     = level_q;
  assign idle      = (level_q == '0) && (state_q == IDLE);
  assign push      = op_valid && op_ready && !flush;

  // The head entry is decoded before the pop so a bad index retires on the very next cycle.
  assign head_op   = mem[rd_ptr];
  assign head_idx  = head_op[CH_IDX_LSB +: CH_IDX_BITS];
  assign head_bad  = 32'(head_idx) >= NUM_CH;
  assign head_mask = NUM_CH'(1) << head_idx;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    trig_d  = '0;
    done_d  = 1'b0;
    bad_d   = 1'b0;
    to_d    = 1'b0;
    cnt_inc = 1'b0;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      wd_d    = '0;
    end else if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            pop = 1'b1;
            if (head_bad) begin
              done_d = 1'b1;
              bad_d  = 1'b1;
            end else begin
              state_d = WAIT_RDY;
            end
          end
        end
        WAIT_RDY: begin
          if (|(ch_rdy & mask_q)) begin
            trig_d  = mask_q;
            wd_d    = '0;
            state_d = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Completion is tested first so a done on the timeout tick still counts.
          if (|(ch_done & mask_q)) begin
            done_d  = 1'b1;
            cnt_inc = 1'b1;
            state_d = IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
            if (TIMEOUT_CYCLES != 0 && wd_d == WD_BITS'(TIMEOUT_CYCLES)) begin
              done_d  = 1'b1;
              to_d    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      wd_q          <= '0;
      mask_q        <= '0;
      ch_op         <= '0;
      ch_trigger    <= '0;
      op_done       <= 1'b0;
      err_bad_ch    <= 1'b0;
      err_timeout   <= 1'b0;
      ops_completed <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      ch_trigger  <= trig_d;
      op_done     <= done_d;
      err_bad_ch  <= bad_d;
      err_timeout <= to_d;
      if (cnt_inc) ops_completed <= ops_completed + 1'b1;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          ch_op  <= head_op;
          mask_q <= head_mask;
        end
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is left unreset; the pointers and level alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= op_in;
  end

endmodule
